// File: rtl/frame_sched.sv
// -----------------------------------------------------------------------------
// frame_sched
//
// Receives 128-bit trace frames from the trace-clock domain. Each frame is
// announced by a toggle on FrAvail. Frames are buffered in a small circular
// FIFO and sent out as eight 16-bit words over a valid/ready stream, most
// significant word first. This block also owns the trace bus width code. A new
// width is applied only when nothing is buffered or in flight. The first frame
// captured after a width switch is corrupt, so it is thrown away.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   FrAvail      frame-ready toggle (trace-clock domain, synchronised here)
//   Frame        last completed frame, stable for >= 4 clk after a toggle
//   widthReq     requested width code
//   width        applied width code
//   dOut         outbound frame word
//   dValid       dOut valid
//   dReady       consumer ready
//   dLast        dOut is word 7 of its frame
//   fill         frames buffered, including the one being sent
//   ovfCount     frames dropped on a full buffer (saturating)
//   traceActive  frames seen within the last 2^IDLE_BITS-1 cycles
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | nothing being sent; may start a frame or apply a width change
// SEND    | presenting word wordIdx of the head frame
// DISCARD | width just changed; the next captured frame is dropped
// -----------------------------------------------------------------------------
module frame_sched #(
    parameter int DEPTH     = 4,
    parameter int IDLE_BITS = 24
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   FrAvail,
    input  logic [127:0]           Frame,
    input  logic [1:0]             widthReq,
    output logic [1:0]             width,
    output logic [15:0]            dOut,
    output logic                   dValid,
    input  logic                   dReady,
    output logic                   dLast,
    output logic [$clog2(DEPTH):0] fill,
    output logic [7:0]             ovfCount,
    output logic                   traceActive
);

    localparam int PW = $clog2(DEPTH);
    localparam int FW = PW + 1;
    localparam logic [FW-1:0] FILL_MAX = FW'(DEPTH);
    localparam logic [FW-1:0] FILL_ONE = FW'(1);
    localparam logic [FW-1:0] FILL_ZERO = '0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SEND    = 2'd1,
        DISCARD = 2'd2
    } stateT;

    stateT                state;
    stateT                stateNext;
    logic [2:0]           wordIdx;
    logic [2:0]           wordIdxNext;
    logic [1:0]           widthNext;

    logic                 frSync1;
    logic                 frSync2;
    logic                 frSyncD;
    logic                 newFrame;

    logic [127:0]         frameMem [DEPTH];
    logic [PW-1:0]        wrPtr;
    logic [PW-1:0]        rdPtr;
    logic [FW-1:0]        fillCnt;
    logic [IDLE_BITS-1:0] idleCnt;

    logic                 handshake;
    logic                 pop;
    logic                 wrEn;
    logic                 dropOvf;
    logic [127:0]         headFrame;
    logic [6:0]           bitBase;
    logic [15:0]          headWord;

    // Either toggle polarity marks a frame.
    assign newFrame  = frSync2 ^ frSyncD;

    assign handshake = (state == SEND) && dReady;
    assign pop       = handshake && (wordIdx == 3'd7);

    // A full buffer can still take a frame when the head leaves in the same
    // cycle. Frames arriving in DISCARD are dropped without counting overflow.
    assign wrEn    = newFrame && (state != DISCARD) && ((fillCnt < FILL_MAX) || pop);
    assign dropOvf = newFrame && (state != DISCARD) && !wrEn;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            frSync1  <= 1'b0;
            frSync2  <= 1'b0;
            frSyncD  <= 1'b0;
            wrPtr    <= '0;
            rdPtr    <= '0;
            fillCnt  <= '0;
            ovfCount <= '0;
            idleCnt  <= '0;
            state    <= IDLE;
            wordIdx  <= '0;
            width    <= '0;
        end else begin
            frSync1 <= FrAvail;
            frSync2 <= frSync1;
            frSyncD <= frSync2;

            if (wrEn) begin
                wrPtr <= wrPtr + PW'(1);
            end
            if (pop) begin
                rdPtr <= rdPtr + PW'(1);
            end
            unique case ({wrEn, pop})
                2'b10:   fillCnt <= fillCnt + FILL_ONE;
                2'b01:   fillCnt <= fillCnt - FILL_ONE;
                default: fillCnt <= fillCnt;
            endcase

            if (dropOvf && (ovfCount != 8'hFF)) begin
                ovfCount <= ovfCount + 8'd1;
            end

            if (newFrame) begin
                idleCnt <= '1;
            end else if (idleCnt != '0) begin
                idleCnt <= idleCnt - IDLE_BITS'(1);
            end

            state   <= stateNext;
            wordIdx <= wordIdxNext;
            width   <= widthNext;
        end
    end

    // Frame storage has no reset; reads are only exposed while in SEND.
    always_ff @(posedge clk) begin
        if (wrEn) begin
            frameMem[wrPtr] <= Frame;
        end
    end

    always_comb begin
        stateNext   = state;
        wordIdxNext = wordIdx;
        widthNext   = width;
        unique case (state)
            IDLE: begin
                if ((fillCnt == FILL_ZERO) && (widthReq != width)) begin
                    widthNext = widthReq;
                    stateNext = DISCARD;
                end else if (fillCnt != FILL_ZERO) begin
                    // Width still matching is the normal case. If widthReq
                    // moved while frames were already buffered, those frames
                    // are drained first so the change cannot stall forever.
                    stateNext   = SEND;
                    wordIdxNext = '0;
                end
            end
            SEND: begin
                if (handshake) begin
                    if (wordIdx == 3'd7) begin
                        // Another frame remains after this pop, so the next
                        // frame follows with no bubble.
                        if ((fillCnt > FILL_ONE) || wrEn) begin
                            wordIdxNext = '0;
                        end else begin
                            stateNext = IDLE;
                        end
                    end else begin
                        wordIdxNext = wordIdx + 3'd1;
                    end
                end
            end
            DISCARD: begin
                if (newFrame) begin
                    stateNext = IDLE;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Word i sits at bits 127-16i down to 112-16i; ~wordIdx equals 7-i.
    always_comb begin
        headFrame = frameMem[rdPtr];
        bitBase   = {~wordIdx, 4'b0000};
        headWord  = headFrame[bitBase +: 16];
    end

    always_comb begin
        dValid      = (state == SEND);
        dLast       = dValid && (wordIdx == 3'd7);
        dOut        = dValid ? headWord : 16'h0000;
        fill        = fillCnt;
        traceActive = (idleCnt != '0);
    end

endmodule

// File: tb/tb_frame_sched.sv
// Bench for frame_sched: frames expected at the output are held in a queue of
// whole 128-bit frames, and each handshaken word is compared against the
// 16-bit slice of the oldest frame in that queue.
module tb_frame_sched;

    localparam int DEPTH     = 4;
    localparam int IDLE_BITS = 4;

    logic         clk;
    logic         rst;
    logic         FrAvail;
    logic [127:0] Frame;
    logic [1:0]   widthReq;
    logic [1:0]   width;
    logic [15:0]  dOut;
    logic         dValid;
    logic         dReady;
    logic         dLast;
    logic [2:0]   fill;
    logic [7:0]   ovfCount;
    logic         traceActive;

    frame_sched #(.DEPTH(DEPTH), .IDLE_BITS(IDLE_BITS)) dut (
        .clk        (clk),
        .rst        (rst),
        .FrAvail    (FrAvail),
        .Frame      (Frame),
        .widthReq   (widthReq),
        .width      (width),
        .dOut       (dOut),
        .dValid     (dValid),
        .dReady     (dReady),
        .dLast      (dLast),
        .fill       (fill),
        .ovfCount   (ovfCount),
        .traceActive(traceActive)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [127:0] expFrames[$];
    int           monWord   = 0;
    int           wordsSeen = 0;
    int           expOvf    = 0;
    logic         randReady = 1'b0;

    logic         prevStall = 1'b0;
    logic [15:0]  prevOut;
    logic         prevLast;

    typedef struct {
        int nFrames;
        int expFill;
        int expOvfDelta;
    } vecT;
    vecT vecs[5];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Called at posedge+1; keeps Frame stable for 5 cycles after the toggle.
    task automatic sendFrame(input logic [127:0] data);
        Frame   = data;
        FrAvail = ~FrAvail;
        repeat (5) @(posedge clk);
        #1;
    endtask

    task automatic drain(input string nm);
        int cyc = 0;
        dReady = 1'b1;
        while ((expFrames.size() != 0 || fill != 0 || dValid) && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check({nm, "_drain_timeout"}, 32'(cyc < 2000), 32'd1);
        check({nm, "_fill_zero"}, 32'(fill), 32'd0);
    endtask

    // Output monitor: sampled on the falling edge, where dValid/dReady show
    // whether a handshake will happen at the next rising edge.
    always @(negedge clk) begin
        logic [127:0] shifted;
        if (!rst) begin
            prevStall = 1'b0;
        end else begin
            if (prevStall) begin
                check("stall_valid", 32'(dValid), 32'd1);
                check("stall_dout", 32'(dOut), 32'(prevOut));
                check("stall_dlast", 32'(dLast), 32'(prevLast));
            end
            if (dValid && dReady) begin
                if (expFrames.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_word: got 0x%0h expected no word", dOut);
                end else begin
                    shifted = expFrames[0] >> (16 * (7 - monWord));
                    check("word", 32'(dOut), 32'(shifted[15:0]));
                    check("dlast", 32'(dLast), 32'(monWord == 7));
                    wordsSeen++;
                    if (monWord == 7) begin
                        void'(expFrames.pop_front());
                        monWord = 0;
                    end else begin
                        monWord++;
                    end
                end
            end
            prevStall = dValid && !dReady;
            prevOut   = dOut;
            prevLast  = dLast;
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            dReady = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [127:0] data;
        logic [127:0] frameA;
        int           cyc;
        int           guard;
        int           highCnt;
        int           seenSnap;
        logic         earlyWidth;

        vecs[0] = '{1, 1, 0};
        vecs[1] = '{4, 4, 0};
        vecs[2] = '{6, 4, 2};
        vecs[3] = '{5, 4, 1};
        vecs[4] = '{3, 3, 0};

        clk      = 1'b0;
        rst      = 1'b0;
        FrAvail  = 1'b1;
        widthReq = 2'd0;
        dReady   = 1'b0;
        Frame    = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
        expFrames.push_back(Frame);

        repeat (3) @(posedge clk);
        #1;
        check("rst_width", 32'(width), 32'd0);
        check("rst_dout", 32'(dOut), 32'd0);
        check("rst_dvalid", 32'(dValid), 32'd0);
        check("rst_dlast", 32'(dLast), 32'd0);
        check("rst_fill", 32'(fill), 32'd0);
        check("rst_ovf", 32'(ovfCount), 32'd0);
        check("rst_active", 32'(traceActive), 32'd0);

        // FrAvail high at release counts as exactly one frame.
        dReady = 1'b1;
        rst    = 1'b1;
        cyc    = 0;
        @(negedge clk);
        while (!dValid && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        check("first_frame_timeout", 32'(cyc < 20), 32'd1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("burst_valid_%0d", k), 32'(dValid), 32'd1);
            if (k < 7) @(negedge clk);
        end
        @(negedge clk);
        check("after_frame_valid", 32'(dValid), 32'd0);
        check("after_frame_fill", 32'(fill), 32'd0);
        check("after_frame_queue", 32'(expFrames.size()), 32'd0);
        repeat (10) @(negedge clk);
        check("single_frame_only", 32'(wordsSeen), 32'd8);
        @(posedge clk);
        #1;

        // Burst with the consumer stalled, then drain.
        for (int v = 0; v < 5; v++) begin
            dReady = 1'b0;
            for (int n = 0; n < vecs[v].nFrames; n++) begin
                data = rand128();
                if (n < DEPTH) expFrames.push_back(data);
                sendFrame(data);
            end
            expOvf += vecs[v].expOvfDelta;
            check($sformatf("vec%0d_fill", v), 32'(fill), 32'(vecs[v].expFill));
            check($sformatf("vec%0d_ovf", v), 32'(ovfCount), 32'(expOvf));
            drain($sformatf("vec%0d", v));
        end

        // Full buffer: last word handshakes in the same cycle a new frame lands.
        dReady = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            data = rand128();
            expFrames.push_back(data);
            sendFrame(data);
        end
        check("full_fill_before", 32'(fill), 32'd4);
        dReady = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        data = rand128();
        expFrames.push_back(data);
        Frame   = data;
        FrAvail = ~FrAvail;
        repeat (3) @(posedge clk);
        #1;
        check("full_pop_write_fill", 32'(fill), 32'd4);
        check("full_pop_write_ovf", 32'(ovfCount), 32'(expOvf));
        repeat (2) @(posedge clk);
        #1;
        drain("full_pop_write");

        // Width change deferred until the buffer drains; next frame discarded.
        dReady = 1'b0;
        for (int n = 0; n < 2; n++) begin
            data = rand128();
            expFrames.push_back(data);
            sendFrame(data);
        end
        widthReq = 2'd3;
        repeat (3) @(posedge clk);
        #1;
        check("width_held_buffered", 32'(width), 32'd0);
        check("width_fill_two", 32'(fill), 32'd2);
        dReady     = 1'b1;
        earlyWidth = 1'b0;
        cyc        = 0;
        while (fill != 0 && cyc < 500) begin
            if (width != 2'd0) earlyWidth = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check("width_drain_timeout", 32'(cyc < 500), 32'd1);
        check("width_deferred", 32'(earlyWidth), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("width_applied", 32'(width), 32'd3);
        frameA = rand128();
        sendFrame(frameA);
        data = rand128();
        expFrames.push_back(data);
        sendFrame(data);
        drain("width_change");
        check("width_discard_ovf", 32'(ovfCount), 32'(expOvf));
        check("width_final", 32'(width), 32'd3);

        // Random consumer backpressure.
        randReady = 1'b1;
        for (int f = 0; f < 24; f++) begin
            guard = 0;
            while (expFrames.size() >= DEPTH && guard < 500) begin
                @(posedge clk);
                #1;
                guard++;
            end
            check("rand_space_timeout", 32'(guard < 500), 32'd1);
            data = rand128();
            expFrames.push_back(data);
            Frame   = data;
            FrAvail = ~FrAvail;
            repeat ($urandom_range(5, 15)) @(posedge clk);
            #1;
        end
        randReady = 1'b0;
        @(posedge clk);
        #2;
        drain("random");
        check("random_ovf", 32'(ovfCount), 32'(expOvf));

        // Trace activity timeout.
        repeat (20) @(posedge clk);
        #1;
        check("active_quiet", 32'(traceActive), 32'd0);
        data = rand128();
        expFrames.push_back(data);
        Frame   = data;
        FrAvail = ~FrAvail;
        highCnt = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (traceActive) highCnt++;
        end
        check("active_cycles", 32'(highCnt), 32'd15);
        @(posedge clk);
        #1;
        drain("active");

        // Overflow counter saturation.
        dReady = 1'b0;
        for (int n = 0; n < DEPTH; n++) begin
            data = rand128();
            expFrames.push_back(data);
            sendFrame(data);
        end
        for (int n = 0; n < 256; n++) begin
            sendFrame(rand128());
            if (expOvf < 255) expOvf++;
        end
        check("ovf_saturate", 32'(ovfCount), 32'(expOvf));
        check("ovf_sat_fill", 32'(fill), 32'd4);

        // Reset in the middle of a frame.
        dReady = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("midsend_valid", 32'(dValid), 32'd1);
        rst = 1'b0;
        #1;
        check("midrst_dvalid", 32'(dValid), 32'd0);
        check("midrst_dout", 32'(dOut), 32'd0);
        check("midrst_dlast", 32'(dLast), 32'd0);
        check("midrst_fill", 32'(fill), 32'd0);
        check("midrst_ovf", 32'(ovfCount), 32'd0);
        check("midrst_width", 32'(width), 32'd0);
        check("midrst_active", 32'(traceActive), 32'd0);
        expFrames.delete();
        monWord  = 0;
        FrAvail  = 1'b0;
        widthReq = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        seenSnap = wordsSeen;
        rst      = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check("postrst_no_words", 32'(wordsSeen), 32'(seenSnap));
        check("postrst_fill", 32'(fill), 32'd0);
        check("postrst_valid", 32'(dValid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
